// File: rtl/iser_align_pkg.sv
// iser_align_pkg: shared types and constants for the per-lane word aligner.
//   align_state_t : alignment FSM states.
//   off_w()       : bit-offset width for a given word width.
//   MM_CNT_W      : width of the optional mismatch statistics counter,
//                   which exists only when ISER_ALIGN_STATS_EN is defined.
package iser_align_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        VERIFY,
        LOCKED,
        FAIL
    } align_state_t;

    localparam int unsigned MM_CNT_W = 8;

    function automatic int unsigned off_w(input int unsigned word_w);
        return $clog2(word_w);
    endfunction

endpackage

// File: rtl/iser_word_asm.sv
// iser_word_asm: builds WORD_W-bit words from the 2-bit IDDR output.
//   data_clk  : lane DCO clock
//   rst_n     : asynchronous active-low reset
//   din       : deserializer pair, din[1] is the earlier serial bit
//   slip_off  : bit offset of the word boundary inside the shift register
//   window    : combinational candidate word at the current offset
//   strobe    : high on the last phase of each word period
//   word      : registered window, loaded on strobe (MSB = earliest bit)
//   word_vld  : one-cycle strobe that marks a new word
module iser_word_asm #(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned OFF_W  = 4
) (
    input  logic              data_clk,
    input  logic              rst_n,
    input  logic [1:0]        din,
    input  logic [OFF_W-1:0]  slip_off,
    output logic [WORD_W-1:0] window,
    output logic              strobe,
    output logic [WORD_W-1:0] word,
    output logic              word_vld
);

    localparam logic [OFF_W-1:0] PH_MAX = OFF_W'(WORD_W / 2 - 1);

    logic [2*WORD_W-1:0] sr;
    logic [OFF_W-1:0]    ph;

    // Phase counter is never cleared by alignment, so word cadence stays free-running.
    assign strobe = (ph == PH_MAX);

    // Offset 0 takes the newest WORD_W bits; larger offsets reach further back in time.
    always_comb begin
        window = WORD_W'(sr >> slip_off);
    end

    always_ff @(posedge data_clk or negedge rst_n) begin
        if (!rst_n) begin
            sr       <= '0;
            ph       <= '0;
            word     <= '0;
            word_vld <= 1'b0;
        end else begin
            sr       <= {sr[2*WORD_W-3:0], din};
            ph       <= strobe ? '0 : ph + OFF_W'(1);
            word_vld <= strobe;
            if (strobe) begin
                word <= window;
            end
        end
    end

endmodule

// File: rtl/iser_align_ctrl.sv
// iser_align_ctrl: word-alignment controller for one deserialized DDR lane.
// Bit-slips the word boundary until TRAIN_PAT is seen MATCH_N times in a row.
//   data_clk     : lane DCO clock
//   rst_n        : asynchronous active-low reset
//   align_start  : single-cycle pulse, (re)starts alignment from offset 0
//   din          : deserializer pair, din[1] is the earlier serial bit
//   word         : aligned word, MSB is the earliest bit
//   word_vld     : one-cycle word strobe (in every state; gate on locked)
//   locked       : alignment achieved
//   align_fail   : sticky, every offset tried without lock
//   slip_off     : current bit offset
//   mismatch_cnt : saturating comparison-mismatch count, only present
//                  when the macro ISER_ALIGN_STATS_EN is defined
module iser_align_ctrl
    import iser_align_pkg::*;
#(
    parameter int unsigned       WORD_W    = 16,
    parameter logic [WORD_W-1:0] TRAIN_PAT = WORD_W'(16'hA1F3),
    parameter int unsigned       MATCH_N   = 4
) (
    input  logic                       data_clk,
    input  logic                       rst_n,
    input  logic                       align_start,
    input  logic [1:0]                 din,
    output logic [WORD_W-1:0]          word,
    output logic                       word_vld,
    output logic                       locked,
    output logic                       align_fail,
    output logic [off_w(WORD_W)-1:0]   slip_off
`ifdef ISER_ALIGN_STATS_EN
    ,
    output logic [MM_CNT_W-1:0]        mismatch_cnt
`endif
);

    localparam int unsigned      OFF_W     = off_w(WORD_W);
    localparam int unsigned      ATT_W     = OFF_W + 1;
    localparam logic [OFF_W-1:0] OFF_MAX   = OFF_W'(WORD_W - 1);
    localparam logic [ATT_W-1:0] ATT_LIM   = ATT_W'(WORD_W);
    localparam logic [3:0]       MATCH_LIM = 4'(MATCH_N);

    align_state_t      state;
    logic [ATT_W-1:0]  attempts;
    logic [3:0]        mcnt;
    logic [WORD_W-1:0] window;
    logic              strobe;
    logic              hunting;
    logic              match;
    logic [ATT_W-1:0]  att_nxt;
    logic [3:0]        mcnt_nxt;

    iser_word_asm #(
        .WORD_W (WORD_W),
        .OFF_W  (OFF_W)
    ) u_word_asm (
        .data_clk (data_clk),
        .rst_n    (rst_n),
        .din      (din),
        .slip_off (slip_off),
        .window   (window),
        .strobe   (strobe),
        .word     (word),
        .word_vld (word_vld)
    );

    assign hunting  = (state == SEARCH) || (state == VERIFY);
    assign match    = (window == TRAIN_PAT);
    assign att_nxt  = attempts + ATT_W'(1);
    assign mcnt_nxt = mcnt + 4'd1;

    // SEARCH and VERIFY share one update: mcnt is zero in SEARCH, so a
    // first match yields mcnt=1 and MATCH_N==1 locks straight from SEARCH.
    // align_start has priority, which discards a coincident strobe's comparison.
    always_ff @(posedge data_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            slip_off   <= '0;
            attempts   <= '0;
            mcnt       <= '0;
            locked     <= 1'b0;
            align_fail <= 1'b0;
        end else if (align_start) begin
            state      <= SEARCH;
            slip_off   <= '0;
            attempts   <= '0;
            mcnt       <= '0;
            locked     <= 1'b0;
            align_fail <= 1'b0;
        end else if (strobe && hunting) begin
            if (match) begin
                mcnt <= mcnt_nxt;
                if (mcnt_nxt == MATCH_LIM) begin
                    state  <= LOCKED;
                    locked <= 1'b1;
                end else begin
                    state <= VERIFY;
                end
            end else begin
                mcnt     <= '0;
                attempts <= att_nxt;
                slip_off <= (slip_off == OFF_MAX) ? '0 : slip_off + OFF_W'(1);
                if (att_nxt == ATT_LIM) begin
                    state      <= FAIL;
                    align_fail <= 1'b1;
                end else begin
                    state <= SEARCH;
                end
            end
        end
    end

`ifdef ISER_ALIGN_STATS_EN
    always_ff @(posedge data_clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_cnt <= '0;
        end else if (align_start) begin
            mismatch_cnt <= '0;
        end else if (strobe && hunting && !match && (mismatch_cnt != '1)) begin
            mismatch_cnt <= mismatch_cnt + MM_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_iser_align_ctrl.sv
// tb_iser_align_ctrl: self-checking bench for iser_align_ctrl.
// The reference keeps the whole serial bit history and derives each window
// directly from it; the slip offset is modelled as (attempts mod WORD_W).
module tb_iser_align_ctrl;

    localparam int          W   = 16;
    localparam logic [15:0] PAT = 16'hA1F3;
    localparam int          MN  = 4;

    logic          data_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          align_start = 1'b0;
    logic [1:0]    din = 2'b00;
    logic [W-1:0]  word;
    logic          word_vld;
    logic          locked;
    logic          align_fail;
    logic [3:0]    slip_off;
`ifdef ISER_ALIGN_STATS_EN
    logic [7:0]    mismatch_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // reference model state
    bit           hist[$];
    int           cyc;
    int           tries;
    int           run;
    bit           hunting;
    bit           lk;
    bit           fl;
    logic [W-1:0] e_word;
    bit           e_vld;
    int           mm;

    iser_align_ctrl #(
        .WORD_W    (W),
        .TRAIN_PAT (PAT),
        .MATCH_N   (MN)
    ) dut (
        .data_clk    (data_clk),
        .rst_n       (rst_n),
        .align_start (align_start),
        .din         (din),
        .word        (word),
        .word_vld    (word_vld),
        .locked      (locked),
        .align_fail  (align_fail),
        .slip_off    (slip_off)
`ifdef ISER_ALIGN_STATS_EN
        ,
        .mismatch_cnt (mismatch_cnt)
`endif
    );

    always #5 data_clk = ~data_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        cyc     = 0;
        tries   = 0;
        run     = 0;
        hunting = 0;
        lk      = 0;
        fl      = 0;
        e_word  = '0;
        e_vld   = 0;
        mm      = 0;
    endtask

    // Window at offset 'off': the W serial bits ending 'off' bits before the newest.
    function automatic logic [W-1:0] window_at(input int off);
        logic [W-1:0] w = '0;
        int L = hist.size();
        for (int j = 0; j < W; j++) begin
            int idx = L - off - W + j;
            bit b = (idx >= 0) ? hist[idx] : 1'b0;
            w = {w[W-2:0], b};
        end
        return w;
    endfunction

    task automatic model_edge(input logic [1:0] d, input logic st);
        if (cyc % (W / 2) == W / 2 - 1) begin
            logic [W-1:0] w;
            w      = window_at(tries % W);
            e_word = w;
            e_vld  = 1;
            if (!st && hunting) begin
                if (w == PAT) begin
                    run++;
                    if (run == MN) begin
                        lk = 1;
                        hunting = 0;
                    end
                end else begin
                    run = 0;
                    tries++;
                    if (mm < 255) mm++;
                    if (tries == W) begin
                        fl = 1;
                        hunting = 0;
                    end
                end
            end
        end else begin
            e_vld = 0;
        end
        if (st) begin
            hunting = 1;
            tries   = 0;
            run     = 0;
            lk      = 0;
            fl      = 0;
            mm      = 0;
        end
        hist.push_back(d[1]);
        hist.push_back(d[0]);
        cyc++;
    endtask

    task automatic check_outputs();
        check("word", word, e_word);
        check("word_vld", word_vld, e_vld);
        check("locked", locked, lk);
        check("align_fail", align_fail, fl);
        check("slip_off", slip_off, tries % W);
`ifdef ISER_ALIGN_STATS_EN
        check("mismatch_cnt", mismatch_cnt, mm);
`endif
    endtask

    // src >= 0: repeated PAT placed so that it aligns at offset src;
    // src == -1: all zeros; src == -2: random bits.
    function automatic logic [1:0] next_din(input int src);
        logic [W-1:0] p = PAT;
        int i = hist.size();
        if (src == -1) return 2'b00;
        if (src == -2) return 2'($urandom_range(0, 3));
        return {p[W-1-((i + 2 + src) % W)], p[W-1-((i + 3 + src) % W)]};
    endfunction

    // Called at a negedge; returns at the following negedge after checking.
    task automatic step(input int src, input logic st);
        logic [1:0] d;
        d = next_din(src);
        din = d;
        align_start = st;
        @(posedge data_clk);
        model_edge(d, st);
        @(negedge data_clk);
        align_start = 1'b0;
        check_outputs();
    endtask

    task automatic warm(input int src, input int n);
        for (int i = 0; i < n; i++) step(src, 1'b0);
    endtask

    // Pulse align_start on the first cycle of a word period (no strobe collision).
    task automatic start_aligned(input int src);
        for (int i = 0; i < W && (cyc % (W / 2) != 0); i++) step(src, 1'b0);
        step(src, 1'b1);
    endtask

    // Step until lock or fail; returns number of word_vld strobes seen.
    task automatic run_to_end(input int src, input int budget, output int nstb);
        int n = 0;
        nstb = 0;
        while (!locked && !align_fail && n < budget) begin
            step(src, 1'b0);
            if (word_vld) nstb++;
            n++;
        end
        check("settled", locked | align_fail, 1);
    endtask

    initial begin
        int nstb;
        int k;
        int n;

        // reset state
        #1;
        model_reset();
        check("rst_word", word, 0);
        check("rst_word_vld", word_vld, 0);
        check("rst_locked", locked, 0);
        check("rst_align_fail", align_fail, 0);
        check("rst_slip_off", slip_off, 0);
`ifdef ISER_ALIGN_STATS_EN
        check("rst_mismatch_cnt", mismatch_cnt, 0);
`endif
        @(negedge data_clk);
        rst_n = 1'b1;

        // idle: words flow, no alignment activity
        warm(5, 20);
        check("idle_locked", locked, 0);

        // offset 5: 5 mismatches + 4 matches
        start_aligned(5);
        run_to_end(5, 300, nstb);
        check("off5_strobes", nstb, 9);
        check("off5_locked", locked, 1);
        check("off5_slip", slip_off, 5);
        check("off5_word", word, 16'hA1F3);
`ifdef ISER_ALIGN_STATS_EN
        check("off5_mm", mismatch_cnt, 5);
`endif
        warm(5, 16);
        check("off5_word_hold", word, 16'hA1F3);

        // asynchronous reset while locked
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_locked", locked, 0);
        check("arst_word", word, 0);
        check("arst_word_vld", word_vld, 0);
        check("arst_slip", slip_off, 0);
        check("arst_fail", align_fail, 0);
        @(negedge data_clk);
        model_reset();
        rst_n = 1'b1;

        // offset 0: exactly MATCH_N strobes
        warm(0, 20);
        start_aligned(0);
        run_to_end(0, 300, nstb);
        check("off0_strobes", nstb, MN);
        check("off0_slip", slip_off, 0);
        check("off0_locked", locked, 1);

        // all zeros: every offset tried, slip_off wraps to 0
        warm(-1, 20);
        start_aligned(-1);
        run_to_end(-1, 400, nstb);
        check("zero_strobes", nstb, W);
        check("zero_fail", align_fail, 1);
        check("zero_locked", locked, 0);
        check("zero_slip", slip_off, 0);

        // offset 3 with a corrupted word during verification
        warm(3, 20);
        start_aligned(3);
        n = 0;
        while (run < 1 && n < 200) begin
            step(3, 1'b0);
            n++;
        end
        check("corrupt_reached_verify", run, 1);
        warm(-1, 8);
        run_to_end(3, 400, nstb);
        check("corrupt_fail", align_fail, 1);
        check("corrupt_locked", locked, 0);

        // align_start coincident with a strobe mid-verification
        warm(7, 20);
        start_aligned(7);
        n = 0;
        while (run < 2 && n < 200) begin
            step(7, 1'b0);
            n++;
        end
        check("coinc_reached_verify", run, 2);
        for (int i = 0; i < W && (cyc % (W / 2) != W / 2 - 1); i++) step(7, 1'b0);
        step(7, 1'b1);
        check("coinc_vld", word_vld, 1);
        check("coinc_slip", slip_off, 0);
        check("coinc_locked", locked, 0);
        run_to_end(7, 300, nstb);
        check("coinc_lock_slip", slip_off, 7);
        check("coinc_lock", locked, 1);

        // random offsets with random start phase
        for (int t = 0; t < 4; t++) begin
            k = $urandom_range(0, W - 1);
            warm(k, $urandom_range(10, 30));
            step(k, 1'b1);
            run_to_end(k, 300, nstb);
            check("rand_locked", locked, 1);
            check("rand_slip", slip_off, k);
        end

        // random noise stream
        warm(-2, 10);
        step(-2, 1'b1);
        run_to_end(-2, 400, nstb);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iser_align_ctrl.md
# iser_align_ctrl

Word-alignment controller for a deserialized DDR lane. It accumulates the 2-bit-per-clock output of a lane's IDDR deserializer into WORD_W-bit words and searches a fixed training pattern by bit-slipping the word boundary. It reports lock, then delivers aligned words to the downstream capture logic. One instance sits per lane, clocked by that lane's DCO clock.

## Interface
- WORD_W, 16: word width in bits; even, 4..32.
- TRAIN_PAT, 16'hA1F3: training word; must be unique under all WORD_W rotations.
- MATCH_N, 4: consecutive matching words required for lock; 1..15.
- data_clk  in  1: DCO clock, only clock.
- rst_n  in  1: asynchronous active-low reset.
- align_start  in  1: single-cycle pulse; (re)starts alignment from offset 0.
- din  in  2: deserializer pair; din[1] is the earlier serial bit.
- word  out  WORD_W: aligned word, MSB is the earliest bit.
- word_vld  out  1: one-cycle strobe, word valid.
- locked  out  1: alignment achieved.
- align_fail  out  1: sticky; all offsets exhausted without lock.
- slip_off  out  $clog2(WORD_W): current bit offset.
- mismatch_cnt  out  8: present only with ISER_ALIGN_STATS_EN.

## Operation
- Shift register sr[2*WORD_W-1:0] <= {sr[2*WORD_W-3:0], din} every cycle.
- Phase counter ph runs 0..WORD_W/2-1 and wraps. The word strobe occurs at ph==WORD_W/2-1.
- Window = sr[slip_off+WORD_W-1 : slip_off]. It is sampled into word on the strobe.
- States:
  - IDLE: no comparison.
  - SEARCH: compare window to TRAIN_PAT on each strobe.
    - Match: go to VERIFY with mcnt=1.
    - Mismatch: increment slip_off and attempts.
  - VERIFY: on each strobe, match increments mcnt; reaching MATCH_N goes to LOCKED. Mismatch increments slip_off and attempts, then returns to SEARCH.
  - LOCKED: locked=1. Words pass through. No further comparison.
  - FAIL: align_fail=1, locked=0.
- slip_off wraps from WORD_W-1 to 0.
- attempts reaching WORD_W goes to FAIL. This means every offset has been tried once.
- align_start in any state:
  - Clears slip_off, attempts, mcnt, locked and align_fail.
  - Enters SEARCH on the next cycle.
  - ph is not reset. Word cadence is free-running.
- A new slip_off takes effect at the next strobe. No words are skipped.
- Simultaneous align_start and strobe: align_start wins and that strobe's comparison is discarded.
- word_vld strobes in all states, so the downstream logic gates on locked.

## Timing
- Reset values:
  - word=0, word_vld=0, locked=0, align_fail=0, slip_off=0.
  - ph=0, sr=0, state=IDLE, mismatch_cnt=0.
- Deserialized bit to word output latency: word and word_vld are registered one cycle after the strobe cycle.
- locked rises in the same cycle word_vld presents the MATCH_N-th matching word.
- align_fail rises in the same cycle word_vld presents the word that exhausted the attempts.
- Reset assertion mid-alignment returns all state immediately (asynchronously) to reset values.
- Reset deassertion is synchronized externally.

## Configuration
- ISER_ALIGN_STATS_EN defined:
  - Port mismatch_cnt exists.
  - It counts SEARCH/VERIFY comparison mismatches, saturates at 255, and is cleared by align_start.
- Macro undefined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- Package iser_align_pkg holds:
  - the state enum (IDLE, SEARCH, VERIFY, LOCKED, FAIL);
  - OFF_W = $clog2(WORD_W) as a function;
  - the mismatch counter width constant.
- Sub-module iser_word_asm holds the shift register, phase counter, window mux and word register. Its outputs are window, strobe, word and word_vld.
- The FSM and counters stay in iser_align_ctrl.

## Test plan
- Serial stream of repeated TRAIN_PAT at bit offset 5, pulse align_start -> slip_off=5, locked=1 after 5 mismatches plus 4 matches (9 strobes), words equal 16'hA1F3.
- Stream aligned at offset 0 -> locked after exactly MATCH_N=4 strobes, slip_off=0.
- Stream of all 16'h0000 -> align_fail=1 after 16 strobes, locked=0, slip_off=0 (wrapped).
- Stream at offset 3 with one corrupted word during VERIFY -> return to SEARCH at offset 4; slip_off wraps around, then lock at 3 on second pass only if attempts<16. Here attempts hit 16 first, so align_fail=1.
- align_start pulsed mid-VERIFY and coincident with a strobe -> comparison discarded, slip_off=0, state SEARCH, then lock at the correct offset.
- rst_n asserted while LOCKED -> all outputs 0 asynchronously. With ISER_ALIGN_STATS_EN, mismatch_cnt=5 after the offset-5 scenario.
